// File: rtl/lane_change_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_change_serializer_pkg
// Description : Shared types and helpers for the lane change serializer:
//               FSM state encoding, lowest-set-bit index and population
//               count over a mask of up to 32 lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_change_serializer_pkg;

    // Widest lane mask the helpers operate on; narrower masks are zero-padded.
    localparam int c_MAX_LANE = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [4:0] lowestSetIdx(input logic [c_MAX_LANE-1:0] mask);
        logic [4:0] res;
        res = '0;
        for (int i = c_MAX_LANE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res = 5'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [5:0] popcount(input logic [c_MAX_LANE-1:0] mask);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_LANE; i++) begin
            cnt = cnt + {5'b0, mask[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_change_serializer_lane_diff.sv
`default_nettype none
// ============================================================================
// Module      : lane_diff
// Description : Per-lane full-width inequality between a new result vector
//               and the previously captured snapshot. Each lane has its own
//               comparator process so only the lanes whose inputs move are
//               re-evaluated.
// Ports       : i_new   - incoming lane vector (lane k at [k*LANE_W +: LANE_W])
//               i_old   - captured snapshot, same layout
//               o_diff  - bit k set when lane k differs
// Revision    : 1.0 - initial release
// ============================================================================
module lane_diff
    import lane_change_serializer_pkg::*;
#(
    parameter int N_LANE = 5,
    parameter int LANE_W = 8
) (
    input  logic [N_LANE*LANE_W-1:0] i_new,
    input  logic [N_LANE*LANE_W-1:0] i_old,
    output logic [N_LANE-1:0]        o_diff
);

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        logic w_ne;
        always_comb begin
            w_ne = (i_new[k*LANE_W +: LANE_W] != i_old[k*LANE_W +: LANE_W]);
        end
        assign o_diff[k] = w_ne;
    end

endmodule
`default_nettype wire

// File: rtl/lane_change_serializer.sv
`default_nettype none
// ============================================================================
// Module      : lane_change_serializer
// Description : Captures a vector of N_LANE lane results under valid/ready,
//               compares it lane-by-lane against the previous capture and
//               streams only the changed lanes as (index, data) beats in
//               ascending index order, one beat per cycle.
// Ports       : i_clk, i_arst_n         - clock, async active-low reset
//               i_lanes, i_valid, o_ready - input vector handshake
//               o_valid, o_idx, o_data, o_last, i_ready - output beat stream
//               o_nChanged              - changed-lane count of last accept
// Options     : LANE_CHANGE_SERIALIZER_FIRSTALL_EN - when defined, the first
//               vector accepted after reset reports every lane as changed.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_change_serializer
    import lane_change_serializer_pkg::*;
#(
    parameter  int N_LANE = 5,
    parameter  int LANE_W = 8,
    localparam int IDX_W  = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [N_LANE*LANE_W-1:0] i_lanes,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [IDX_W-1:0]         o_idx,
    output logic [LANE_W-1:0]        o_data,
    output logic                     o_last,
    input  logic                     i_ready,
    output logic [IDX_W:0]           o_nChanged
);

    state_t                     r_state;
    logic [N_LANE*LANE_W-1:0]   r_snapshot;
    logic [N_LANE-1:0]          r_dirty;
    logic [IDX_W:0]             r_n_changed;
    logic                       r_ready;
    logic                       r_valid;
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
    logic                       r_first;
`endif

    logic [N_LANE-1:0]          w_diff;
    logic [N_LANE-1:0]          w_new_dirty;
    logic [N_LANE-1:0]          w_rest;
    logic [c_MAX_LANE-1:0]      w_dirty_pad;
    logic [c_MAX_LANE-1:0]      w_new_pad;
    logic [4:0]                 w_low_idx;
    logic [5:0]                 w_pop;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_accept;
    logic                       w_beat;
    logic                       w_last;
    logic                       w_unused_bits;

    lane_diff #(
        .N_LANE (N_LANE),
        .LANE_W (LANE_W)
    ) u_lane_diff (
        .i_new  (i_lanes),
        .i_old  (r_snapshot),
        .o_diff (w_diff)
    );

`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
    assign w_new_dirty = r_first ? '1 : w_diff;
`else
    assign w_new_dirty = w_diff;
`endif

    always_comb begin
        w_dirty_pad                = '0;
        w_dirty_pad[N_LANE-1:0]    = r_dirty;
        w_new_pad                  = '0;
        w_new_pad[N_LANE-1:0]      = w_new_dirty;
    end

    assign w_low_idx = lowestSetIdx(w_dirty_pad);
    assign w_pop     = popcount(w_new_pad);
    assign w_idx     = w_low_idx[IDX_W-1:0];

    // Clearing the lowest set bit is exactly "clear dirty[o_idx]".
    assign w_rest    = r_dirty & (r_dirty - N_LANE'(1));
    assign w_last    = (w_rest == '0);

    assign w_accept  = r_ready & i_valid;
    assign w_beat    = r_valid & i_ready;

    // High bits of the generic helpers are not needed for narrow configs.
    assign w_unused_bits = ^{w_low_idx, w_pop};

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state     <= IDLE;
            r_snapshot  <= '0;
            r_dirty     <= '0;
            r_n_changed <= '0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
            r_first     <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_snapshot  <= i_lanes;
                        r_dirty     <= w_new_dirty;
                        r_n_changed <= w_pop[IDX_W:0];
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
                        r_first     <= 1'b0;
`endif
                        // A vector with no changes produces no beats and
                        // leaves the block ready for the next one.
                        if (|w_new_dirty) begin
                            r_state <= EMIT;
                            r_ready <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (w_beat) begin
                        r_dirty <= w_rest;
                        if (w_last) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_idx      = r_valid ? w_idx : '0;
    assign o_data     = r_valid ? r_snapshot[int'(w_idx)*LANE_W +: LANE_W] : '0;
    assign o_last     = r_valid & w_last;
    assign o_nChanged = r_n_changed;

endmodule
`default_nettype wire

// File: tb/tb_lane_change_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_change_serializer
// Description : Directed scoreboard bench for lane_change_serializer with
//               N_LANE=5, LANE_W=8. Expected beats are queued as vectors are
//               issued; a monitor pops and compares each beat the DUT
//               delivers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_change_serializer;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic [N*W-1:0] lanes = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic           dut_ready;
    logic           dut_valid;
    logic [IW-1:0]  dut_idx;
    logic [W-1:0]   dut_data;
    logic           dut_last;
    logic [IW:0]    dut_nchanged;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    lane_change_serializer #(
        .N_LANE (N),
        .LANE_W (W)
    ) dut (
        .i_clk      (clk),
        .i_arst_n   (arst_n),
        .i_lanes    (lanes),
        .i_valid    (in_valid),
        .o_ready    (dut_ready),
        .o_valid    (dut_valid),
        .o_idx      (dut_idx),
        .o_data     (dut_data),
        .o_last     (dut_last),
        .i_ready    (out_ready),
        .o_nChanged (dut_nchanged)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] vec(input logic [7:0] l0, input logic [7:0] l1,
                                           input logic [7:0] l2, input logic [7:0] l3,
                                           input logic [7:0] l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    task automatic push(input int idx, input logic [7:0] data, input logic last);
        beat_t b;
        b.idx  = IW'(idx);
        b.data = data;
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Monitor: a beat completes at the next rising edge when valid & ready
    // are both high at the falling edge.
    always @(negedge clk) begin
        if (arst_n && dut_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: actual idx=%0d data=%0h required=none",
                         dut_idx, dut_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_idx",  dut_idx,  e.idx);
                chk("beat_data", dut_data, e.data);
                chk("beat_last", dut_last, e.last);
            end
        end
    end

    task automatic send(input logic [N*W-1:0] v);
        int n;
        @(posedge clk);
        #1;
        lanes    = v;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dut_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept_ready", dut_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called at a falling edge; counts cycles with o_valid until o_ready.
    task automatic wait_idle(output int vcyc);
        int n;
        vcyc = 0;
        n = 0;
        while (!dut_ready && n < 50) begin
            if (dut_valid) vcyc++;
            n++;
            @(negedge clk);
        end
        chk("idle_reached", dut_ready, 1);
    endtask

    initial begin
        int len;
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        va = vec(8'h11, 8'h00, 8'h33, 8'h00, 8'h55);
        vb = vec(8'h11, 8'h22, 8'h33, 8'h00, 8'h55);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready",    dut_ready,    1);
        chk("rst_valid",    dut_valid,    0);
        chk("rst_idx",      dut_idx,      0);
        chk("rst_data",     dut_data,     0);
        chk("rst_last",     dut_last,     0);
        chk("rst_nchanged", dut_nchanged, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // First vector all zeros
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
        for (int k = 0; k < N; k++) push(k, 8'h00, k == N - 1);
        send('0);
        @(negedge clk);
        chk("zero_nchanged", dut_nchanged, 5);
        chk("zero_valid",    dut_valid,    1);
        wait_idle(len);
        chk("zero_burst_len", len, 5);
        send('0);
        @(negedge clk);
        chk("repeat_nchanged", dut_nchanged, 0);
        chk("repeat_valid",    dut_valid,    0);
        chk("repeat_ready",    dut_ready,    1);
`else
        send('0);
        @(negedge clk);
        chk("zero_nchanged", dut_nchanged, 0);
        chk("zero_valid",    dut_valid,    0);
        chk("zero_ready",    dut_ready,    1);
`endif

        // Streaming burst of three changed lanes
        push(0, 8'h11, 1'b0);
        push(2, 8'h33, 1'b0);
        push(4, 8'h55, 1'b1);
        send(va);
        @(negedge clk);
        chk("a_ready_busy", dut_ready,    0);
        chk("a_valid",      dut_valid,    1);
        chk("a_nchanged",   dut_nchanged, 3);
        wait_idle(len);
        chk("a_burst_len",  len,          3);
        chk("a_nchanged_hold", dut_nchanged, 3);

        // Single changed lane, downstream stalled for 3 cycles, with
        // upstream traffic during EMIT that must be ignored
        out_ready = 1'b0;
        push(1, 8'h22, 1'b1);
        send(vb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", dut_valid, 1);
            chk("stall_idx",   dut_idx,   1);
            chk("stall_data",  dut_data,  8'h22);
            chk("stall_last",  dut_last,  1);
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            lanes    = vec(8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB);
        end
        in_valid  = 1'b0;
        lanes     = vb;
        out_ready = 1'b1;
        @(negedge clk);
        wait_idle(len);
        chk("b_burst_len", len,          1);
        chk("b_nchanged",  dut_nchanged, 1);

        // Snapshot must still be vb: resending it changes nothing
        send(vb);
        @(negedge clk);
        chk("b_again_nchanged", dut_nchanged, 0);
        chk("b_again_valid",    dut_valid,    0);

        // Reset mid-burst
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        @(negedge clk);
        chk("rst2_nchanged", dut_nchanged, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
        push(0, 8'h11, 1'b0);
        push(1, 8'h00, 1'b0);
        push(2, 8'h33, 1'b0);
        push(3, 8'h00, 1'b0);
        push(4, 8'h55, 1'b1);
`else
        push(0, 8'h11, 1'b0);
        push(2, 8'h33, 1'b0);
        push(4, 8'h55, 1'b1);
`endif
        send(va);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        chk("abort_valid", dut_valid, 0);
        chk("abort_ready", dut_ready, 1);
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
        chk("abort_pending", exp_q.size(), 4);
`else
        chk("abort_pending", exp_q.size(), 2);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // Re-accept after abort: compared against the zero reset snapshot
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
        push(0, 8'h11, 1'b0);
        push(1, 8'h00, 1'b0);
        push(2, 8'h33, 1'b0);
        push(3, 8'h00, 1'b0);
        push(4, 8'h55, 1'b1);
`else
        push(0, 8'h11, 1'b0);
        push(2, 8'h33, 1'b0);
        push(4, 8'h55, 1'b1);
`endif
        send(va);
        @(negedge clk);
        wait_idle(len);
`ifdef LANE_CHANGE_SERIALIZER_FIRSTALL_EN
        chk("re_burst_len", len, 5);
        chk("re_nchanged",  dut_nchanged, 5);
`else
        chk("re_burst_len", len, 3);
        chk("re_nchanged",  dut_nchanged, 3);
`endif
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_change_serializer.md
Name: lane_change_serializer

Overview:
- Downstream consumer of a per-lane combinational stage that computes N_LANE independent results in parallel.
- Captures each result vector under a valid/ready handshake and compares it per lane against the previously captured vector.
- Emits only the changed lanes as (index, data) beats, one per cycle, in ascending index order.
- Gives later logic work proportional to the lanes that changed, not to N_LANE.

Parameters:
- N_LANE, 5, number of lanes; legal range 1..32.
- LANE_W, 8, width of each lane result in bits; minimum 1.
- IDX_W, (N_LANE > 1) ? $clog2(N_LANE) : 1, width of the lane index (localparam, derived).

Ports:
- i_clk  input  1  clock; all state is updated on the rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_lanes  input  N_LANE*LANE_W  lane results; lane k occupies bits [k*LANE_W +: LANE_W].
- i_valid  input  1  upstream asserts that i_lanes is valid.
- o_ready  output  1  block can accept a vector.
- o_valid  output  1  an output beat is presented.
- o_idx  output  IDX_W  lane index of the current beat.
- o_data  output  LANE_W  captured data of lane o_idx.
- o_last  output  1  current beat is the last changed lane of this vector.
- i_ready  input  1  downstream accepts the beat.
- o_nChanged  output  IDX_W+1  count of changed lanes in the most recently accepted vector.

Behaviour:
- Reset:
  - One clock, i_clk; reset is asynchronous and active-low on i_arst_n.
  - While reset is asserted: state=IDLE, snapshot=0, dirty=0, o_nChanged=0.
  - Resulting output values during reset: o_ready=1, o_valid=0, o_idx=0, o_data=0, o_last=0.
- FSM states: IDLE and EMIT.
  - o_ready=1 only in IDLE.
  - o_valid=1 only in EMIT.
- IDLE, on accept (i_valid & o_ready):
  - snapshot <= i_lanes.
  - dirty[k] <= (i_lanes lane k != snapshot lane k).
  - o_nChanged <= popcount of the new dirty mask.
  - Next state is EMIT if any lane changed; otherwise stay in IDLE with o_ready still 1 (zero-change vector: no beats emitted).
- EMIT:
  - o_idx is the lowest set bit of dirty; o_data is snapshot lane o_idx.
  - o_last=1 when exactly one dirty bit remains.
  - On a beat (o_valid & i_ready): clear dirty[o_idx]; if o_last, next state is IDLE.
  - If i_ready=0, all outputs hold stable. o_valid must not drop before the beat completes.
- Latency: a vector accepted at edge t presents its first beat in the cycle after t. With i_ready held at 1, changed lanes stream at one beat per cycle.
- Throughput: the block accepts a new vector no earlier than the cycle after the last beat; there is no overlap between vectors.
- In EMIT, i_valid and i_lanes are ignored. Upstream holds them under the handshake.
- Comparison is a bitwise full-lane compare; no masking.
- o_nChanged holds its value until the next accept.
- Reset asserted mid-EMIT: the burst is aborted immediately; no partial state survives; the next accepted vector is compared against 0.
- N_LANE=1: o_idx is a constant 0 of width 1.

Optional Feature:
- Macro: LANE_CHANGE_SERIALIZER_FIRSTALL_EN.
- Defined: a first-vector flag is set by reset. The first accepted vector after reset marks all N_LANE lanes dirty, regardless of value; o_nChanged=N_LANE. The flag clears on that accept.
- Undefined: the first vector is compared against the all-zero reset snapshot, so zero lanes are not emitted.

Decomposition:
- Package lane_change_serializer_pkg:
  - state enum type (IDLE, EMIT).
  - function lowestSetIdx(mask) returning the index of the lowest set bit.
  - function popcount.
- Sub-module lane_diff:
  - Computes the per-lane mismatch vector.
  - Uses one generate loop with one always_comb per lane, so a change in one lane re-evaluates only that lane's comparator in simulation.
- Top level holds the FSM, snapshot and dirty registers, and the output mux.

Test Plan (N_LANE=5, LANE_W=8):
- Reset, then accept {0,0,0,0,0} -> no beat; o_ready stays 1; o_nChanged=0.
- Accept lanes {0x11,0,0x33,0,0x55} with i_ready=1 -> beats idx 0,2,4 with data 0x11,0x33,0x55 on consecutive cycles; o_last only on idx 4; o_nChanged=3; o_ready=0 during the burst and 1 the cycle after.
- Then accept {0x11,0x22,0x33,0,0x55} with i_ready low for 3 cycles -> single beat idx 1, data 0x22, held stable for all 3 stall cycles; o_last=1.
- While in EMIT, toggle i_valid with new data -> ignored; the burst content is unchanged.
- Assert i_arst_n=0 between the beats for idx 0 and idx 2 of a burst -> o_valid drops at once. Re-accepting {0x11,0,0x33,0,0x55} then emits idx 0, 2, 4 again.
- With LANE_CHANGE_SERIALIZER_FIRSTALL_EN defined: first vector all zeros -> 5 beats, idx 0..4, data 0; o_nChanged=5. Repeating the same vector -> no beats.
